// File: rtl/spi_slave_mem_writer.sv
// SPI mode-0 receive endpoint: deserialises MSB-first 32-bit words and writes
// each one to data memory at an auto-incrementing word address.
module spi_slave_mem_writer #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          DEPTH_WORDS = 16,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic        i_SPI_Clk,
    input  logic        i_SPI_MOSI,
    input  logic        i_SPI_CS_n,
    input  logic        i_Ptr_Clr,
    output logic        o_Mem_WE,
    output logic [31:0] o_Mem_Addr,
    output logic [31:0] o_Mem_WData,
    output logic        o_RX_DV,
    output logic [31:0] o_RX_Word,
    output logic        o_Wrap,
    output logic        o_Frame_Err,
    output logic        o_Busy
);
    localparam int PTR_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] ST_WAIT_CS_HIGH = 2'd0;
    localparam logic [1:0] ST_IDLE         = 2'd1;
    localparam logic [1:0] ST_RECEIVE      = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, csn_sync_q;
    logic                   sclk_prev_q;
    logic                   sclk_s, mosi_s, csn_s, sclk_rise;

    logic [1:0]       state_q, state_d;
    logic [4:0]       count_q, count_d, cnt_next;
    logic [31:0]      shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      word_q, word_d;
    logic             we_q, we_d, wrap_q, wrap_d, err_q, err_d, busy_q, busy_d;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign csn_s     = csn_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;

    // CS_n resets to the active level so a real high must be observed before
    // the first frame is accepted.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            csn_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_SPI_Clk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], i_SPI_CS_n};
            sclk_prev_q <= sclk_s;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= ST_WAIT_CS_HIGH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_CS_HIGH: if (csn_s)  state_d = ST_IDLE;
            ST_IDLE:         if (!csn_s) state_d = ST_RECEIVE;
            ST_RECEIVE:      if (csn_s)  state_d = ST_IDLE;
            default:                     state_d = ST_WAIT_CS_HIGH;
        endcase
    end

    // Output strobes carry no handshake: o_Mem_WE/o_RX_DV are one-cycle valid
    // pulses with address/data stable alongside, and the sink must accept.
    // An SCLK edge in the deassert cycle is shifted before the CS_n check.
    always_comb begin
        count_d  = count_q;
        cnt_next = count_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        word_d   = word_q;
        we_d     = 1'b0;
        wrap_d   = 1'b0;
        err_d    = 1'b0;
        busy_d   = (state_q == ST_RECEIVE);
        case (state_q)
            ST_RECEIVE: begin
                if (sclk_rise) begin
                    shift_d  = {shift_q[30:0], mosi_s};
                    cnt_next = count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        word_d = {shift_q[30:0], mosi_s};
                        addr_d = BASE_ADDR + {{(30-PTR_W){1'b0}}, ptr_q, 2'b00};
                        we_d   = 1'b1;
                        wrap_d = (ptr_q == PTR_W'(DEPTH_WORDS-1));
                        ptr_d  = ptr_q + PTR_W'(1);
                    end
                end
                if (csn_s) begin
                    err_d   = (cnt_next != 5'd0);
                    count_d = 5'd0;
                end else begin
                    count_d = cnt_next;
                end
            end
            default: count_d = 5'd0;
        endcase
        if (i_Ptr_Clr) ptr_d = '0;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count_q <= 5'd0;
            shift_q <= 32'd0;
            ptr_q   <= '0;
            addr_q  <= BASE_ADDR;
            word_q  <= 32'd0;
            we_q    <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            shift_q <= shift_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            we_q    <= we_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign o_Mem_WE    = we_q;
    assign o_RX_DV     = we_q;
    assign o_Mem_Addr  = addr_q;
    assign o_Mem_WData = word_q;
    assign o_RX_Word   = word_q;
    assign o_Wrap      = wrap_q;
    assign o_Frame_Err = err_q;
    assign o_Busy      = busy_q;
endmodule

// File: tb/tb_spi_slave_mem_writer.sv
// Bench for spi_slave_mem_writer: directed SPI frames, expected writes queued
// at issue time and checked by an independent monitor.
module tb_spi_slave_mem_writer;
    localparam int HALF = 4;
    localparam logic [1:0] ST_IDLE = 2'd1;

    logic        clk, rst_n, sclk, mosi, cs_n, ptr_clr;
    logic        mem_we, rx_dv, wrap, frame_err, busy;
    logic [31:0] mem_addr, mem_wdata, rx_word;

    logic [64:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          err_seen = 0;
    int          exp_err = 0;
    int          exp_ptr = 0;

    spi_slave_mem_writer dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_SPI_Clk(sclk), .i_SPI_MOSI(mosi),
        .i_SPI_CS_n(cs_n), .i_Ptr_Clr(ptr_clr), .o_Mem_WE(mem_we),
        .o_Mem_Addr(mem_addr), .o_Mem_WData(mem_wdata), .o_RX_DV(rx_dv),
        .o_RX_Word(rx_word), .o_Wrap(wrap), .o_Frame_Err(frame_err), .o_Busy(busy)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [64:0] e;
        if (rst_n) begin
            if (mem_we || rx_dv) check("dv_eq_we", {31'd0, rx_dv}, {31'd0, mem_we});
            if (wrap && !mem_we) check("wrap_without_we", 32'd1, 32'd0);
            if (frame_err) err_seen++;
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("addr", mem_addr, e[63:32]);
                    check("wdata", mem_wdata, e[31:0]);
                    check("rx_word", rx_word, e[31:0]);
                    check("wrap", {31'd0, wrap}, {31'd0, e[64]});
                end
            end
        end
    end

    // driver tasks
    task automatic push_exp(input logic [31:0] data, input bit clr);
        logic [31:0] addr;
        logic        w;
        addr = 32'h1000 + 32'(exp_ptr) * 4;
        w = (exp_ptr == 15);
        exp_q.push_back({w, addr, data});
        exp_ptr = clr ? 0 : (exp_ptr + 1) % 16;
    endtask

    task automatic spi_bits(input logic [31:0] data, input int nbits, input bit clr_last);
        for (int i = 0; i < nbits; i++) begin
            mosi = data[31-i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            if (clr_last && i == nbits - 1) begin
                repeat (2) @(negedge clk);
                ptr_clr = 1'b1;
                @(negedge clk);
                ptr_clr = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit clr);
        push_exp(w, clr);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        spi_bits(w, 32, clr);
        repeat (6) @(negedge clk);
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic idle_clear();
        @(negedge clk);
        ptr_clr = 1'b1;
        @(negedge clk);
        ptr_clr = 1'b0;
        exp_ptr = 0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 32'd0);
        check("frame_err_count", err_seen, exp_err);
    endtask

    initial begin
        rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; ptr_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr", mem_addr, 32'h1000);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_word", rx_word, 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("idle_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_addr", mem_addr, 32'h1000);

        // single word
        send_word(32'hDEAD_BEEF, 1'b0);
        drain("single_drain");

        // sequence with wrap
        idle_clear();
        for (int i = 0; i <= 16; i++) send_word(32'(i), 1'b0);
        drain("seq_drain");

        // aborted frame then a clean word at the unchanged address
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        spi_bits(32'hABC0_0000, 12, 1'b0);
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        exp_err++;
        repeat (8) @(negedge clk);
        check("busy_after_abort", {31'd0, busy}, 32'd0);
        send_word(32'h1234_5678, 1'b0);
        drain("abort_drain");

        // pointer clear coinciding with the write of word 3
        idle_clear();
        for (int i = 0; i < 4; i++) send_word(32'h30 + 32'(i), i == 3);
        send_word(32'h34, 1'b0);
        drain("clr_drain");

        // reset in the middle of a frame
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        spi_bits(32'hFFFF_FFFF, 20, 1'b0);
        rst_n = 1'b0;
        exp_ptr = 0;
        @(negedge clk);
        check("midrst_addr", mem_addr, 32'h1000);
        check("midrst_word", rx_word, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        spi_bits(32'hFFFF_FFFF, 12, 1'b0);
        repeat (6) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        send_word(32'hA5A5_A5A5, 1'b0);
        drain("midrst_drain");

        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
